// File: rtl/sw_debounce_if.sv
// Switch conditioning bus: raw pin levels in, debounced levels and edge strobes out.
// pending is a per-bit view of the debounce state machine (1 = PENDING).
interface sw_debounce_if #(
    parameter int WIDTH = 10
) ();
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             change_any;
    logic [WIDTH-1:0] pending;

    // No handshake: sw_raw is a free-running level; all outputs are registered
    // levels or one-cycle strobes, valid every cycle outside reset.
    modport master (
        output sw_raw,
        input  sw_clean,
        input  sw_rise,
        input  sw_fall,
        input  change_any,
        input  pending
    );

    modport slave (
        input  sw_raw,
        output sw_clean,
        output sw_rise,
        output sw_fall,
        output change_any,
        output pending
    );
endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus per-bit tick-based debouncer for slide switches.
// sw_clean only follows a bit after STABLE_TICKS consecutive mismatching ticks.
module sw_debounce #(
    parameter int WIDTH        = 10,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 20
) (
    input logic         clk,
    input logic         reset,
    sw_debounce_if.slave bus
);
    localparam int CW = $clog2(STABLE_TICKS) + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [TW-1:0]    tick_cnt_q;
    logic             tick;

    logic [WIDTH-1:0] clean_q, clean_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             chg_q, chg_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    state_e           state [WIDTH];
    logic [WIDTH-1:0] pending;

    assign tick = (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            tick_cnt_q <= '0;
            clean_q    <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            chg_q      <= 1'b0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            s1_q       <= bus.sw_raw;
            s2_q       <= s1_q;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
            clean_q    <= clean_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            chg_q      <= chg_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // State is implied by s2 vs sw_clean, so a bounce back cancels a pending
    // change on the very next edge regardless of the prescaler.
    always_comb begin
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        pending = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            state[i] = (s2_q[i] != clean_q[i]) ? ST_PENDING : ST_STABLE;
            pending[i] = (state[i] == ST_PENDING);
            case (state[i])
                ST_STABLE: cnt_d[i] = '0;
                ST_PENDING: begin
                    if (tick) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            clean_d[i] = s2_q[i];
                            rise_d[i]  = s2_q[i];
                            fall_d[i]  = ~s2_q[i];
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                end
                default: cnt_d[i] = '0;
            endcase
        end
        chg_d = (|rise_d) | (|fall_d);
    end

    assign bus.sw_clean   = clean_q;
    assign bus.sw_rise    = rise_q;
    assign bus.sw_fall    = fall_q;
    assign bus.change_any = chg_q;
    assign bus.pending    = pending;
endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: one instance at TICK_DIV=1/STABLE_TICKS=4, one at 5/3.
// Expected output events are queued when stimulus is driven and matched at negedge.
module tb_sw_debounce;
  localparam int W = 10;

  typedef struct {
    int           lo;
    int           hi;
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         chg;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_chk;
  int   n_err;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t ea;
  exp_t eb;
  logic [W-1:0] mc_a;
  logic [W-1:0] mc_b;
  logic [W-1:0] last_a;
  logic [W-1:0] last_b;

  sw_debounce_if #(.WIDTH(W)) if_a ();
  sw_debounce_if #(.WIDTH(W)) if_b ();

  sw_debounce #(.WIDTH(W), .TICK_DIV(1), .STABLE_TICKS(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a.slave)
  );

  sw_debounce #(.WIDTH(W), .TICK_DIV(5), .STABLE_TICKS(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  // drivers
  task automatic drive_a(input logic [W-1:0] v, input int lat);
    exp_t e;
    @(posedge clk);
    #2;
    if_a.sw_raw = v;
    if (v != mc_a) begin
      e.lo = cyc + lat; e.hi = cyc + lat;
      e.clean = v; e.rise = v & ~mc_a; e.fall = ~v & mc_a; e.chg = 1'b1;
      exp_a.push_back(e);
      mc_a = v;
    end
  endtask

  task automatic drive_b(input logic [W-1:0] v, input int lo, input int hi);
    exp_t e;
    @(posedge clk);
    #2;
    if_b.sw_raw = v;
    if (v != mc_b) begin
      e.lo = cyc + lo; e.hi = cyc + hi;
      e.clean = v; e.rise = v & ~mc_b; e.fall = ~v & mc_b; e.chg = 1'b1;
      exp_b.push_back(e);
      mc_b = v;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (exp_a.size() == 0 && exp_b.size() == 0) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("drain_pending", exp_a.size() + exp_b.size(), 0);
  endtask

  task automatic check_quiet_a(input string tag);
    check(tag, {if_a.sw_rise, if_a.sw_fall, if_a.change_any}, 0);
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (reset) begin
      last_a = '0;
    end else begin
      if (exp_a.size() > 0 && exp_a[0].hi < cyc) begin
        check("a_event_missing", cyc, exp_a[0].hi);
        void'(exp_a.pop_front());
      end
      if (if_a.sw_clean != last_a || |if_a.sw_rise || |if_a.sw_fall || if_a.change_any) begin
        if (exp_a.size() == 0) begin
          check("a_spurious", {if_a.sw_clean, if_a.sw_rise, if_a.sw_fall, if_a.change_any},
                {last_a, 20'd0, 1'b0});
        end else begin
          ea = exp_a.pop_front();
          if (ea.lo == ea.hi) check("a_cycle", cyc, ea.lo);
          else check("a_in_window", (cyc >= ea.lo && cyc <= ea.hi), 1);
          check("a_clean", if_a.sw_clean, ea.clean);
          check("a_rise", if_a.sw_rise, ea.rise);
          check("a_fall", if_a.sw_fall, ea.fall);
          check("a_change_any", if_a.change_any, ea.chg);
        end
        last_a = if_a.sw_clean;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      last_b = '0;
    end else begin
      if (exp_b.size() > 0 && exp_b[0].hi < cyc) begin
        check("b_event_missing", cyc, exp_b[0].hi);
        void'(exp_b.pop_front());
      end
      if (if_b.sw_clean != last_b || |if_b.sw_rise || |if_b.sw_fall || if_b.change_any) begin
        if (exp_b.size() == 0) begin
          check("b_spurious", {if_b.sw_clean, if_b.sw_rise, if_b.sw_fall, if_b.change_any},
                {last_b, 20'd0, 1'b0});
        end else begin
          eb = exp_b.pop_front();
          check("b_in_window", (cyc >= eb.lo && cyc <= eb.hi), 1);
          check("b_clean", if_b.sw_clean, eb.clean);
          check("b_rise", if_b.sw_rise, eb.rise);
          check("b_fall", if_b.sw_fall, eb.fall);
          check("b_change_any", if_b.change_any, eb.chg);
        end
        last_b = if_b.sw_clean;
      end
    end
  end

  // stimulus
  initial begin
    logic [W-1:0] v;
    n_chk = 0;
    n_err = 0;
    mc_a = '0;
    mc_b = '0;
    reset = 1'b1;
    if_a.sw_raw = 10'h3FF;
    if_b.sw_raw = '0;

    // reset with all switches high: outputs held at zero
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_clean", if_a.sw_clean, 0);
      check("rst_rise", if_a.sw_rise, 0);
      check("rst_fall", if_a.sw_fall, 0);
      check("rst_change_any", if_a.change_any, 0);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    begin
      exp_t e;
      e.lo = cyc + 6; e.hi = cyc + 6;
      e.clean = 10'h3FF; e.rise = 10'h3FF; e.fall = '0; e.chg = 1'b1;
      exp_a.push_back(e);
      mc_a = 10'h3FF;
    end
    drain();
    drive_a(10'h000, 6);
    drain();

    // clean single-bit step up and down
    drive_a(10'h001, 6);
    drain();
    drive_a(10'h000, 6);
    drain();

    // bit3 bounces every cycle, then settles high
    v = '0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #2;
      v[3] = ~v[3];
      if_a.sw_raw = v;
      @(negedge clk);
      check_quiet_a("bounce_quiet");
      check("bounce_clean", if_a.sw_clean, 0);
    end
    drive_a(10'h008, 6);
    drain();
    drive_a(10'h000, 6);
    drain();

    // 3-cycle glitch on bit5 must not get through
    @(posedge clk);
    #2;
    if_a.sw_raw = 10'h020;
    repeat (3) @(posedge clk);
    #2;
    if_a.sw_raw = 10'h000;
    repeat (10) begin
      @(negedge clk);
      check("glitch_clean", if_a.sw_clean, 0);
      check_quiet_a("glitch_quiet");
    end

    // reset while bit2 is mid-qualification
    @(posedge clk);
    #2;
    if_a.sw_raw = 10'h004;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst_clean", if_a.sw_clean, 0);
      check_quiet_a("midrst_quiet");
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    begin
      exp_t e;
      e.lo = cyc + 6; e.hi = cyc + 6;
      e.clean = 10'h004; e.rise = 10'h004; e.fall = '0; e.chg = 1'b1;
      exp_a.push_back(e);
      mc_a = 10'h004;
    end
    drain();

    // prescaled instance: establish 0x200, then bit0 up and bit9 down together
    drive_b(10'h200, 13, 17);
    drain();
    drive_b(10'h001, 13, 17);
    drain();
    // a few random multi-bit patterns on the prescaled instance
    for (int k = 0; k < 3; k++) begin
      drive_b(W'($urandom_range(1, 1023)), 13, 17);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
